// File: rtl/vga_scanout.sv
// VGA scan-out engine with a built-in timing generator and a double-buffered 24-bit framebuffer.
// The producer fills the back buffer. The displayed buffer only flips during vertical blanking.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int H_BITS   = 10,
    parameter int V_BITS   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [H_BITS-1:0] wr_x,
    input  logic [V_BITS-1:0] wr_y,
    input  logic [23:0]       wr_data,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_buf,
    output logic              frame_start,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic              VGA_BLANK_N,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);
    localparam int AW      = 1 + H_BITS + V_BITS;

    localparam logic [HC_W-1:0] H_ONE    = HC_W'(1);
    localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_START = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [VC_W-1:0] V_ONE    = VC_W'(1);
    localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_SWAP   = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] VS_START = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [H_BITS:0] WX_LIM = (H_BITS + 1)'(H_ACTIVE);
    localparam logic [V_BITS:0] WY_LIM = (V_BITS + 1)'(V_ACTIVE);

    logic [HC_W-1:0] h_cnt;
    logic [VC_W-1:0] v_cnt;
    logic            h_wrap;
    logic            v_wrap;
    logic            active;
    logic            hsync_on;
    logic            vsync_on;
    logic            first_pixel;
    logic            swap_point;
    logic            do_swap;
    logic            swap_pending;
    logic            wr_ok;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;
    logic [23:0]     rd_data;
    logic [23:0]     mem [0:(1<<AW)-1];

    assign h_wrap      = (h_cnt == H_LAST);
    assign v_wrap      = (v_cnt == V_LAST);
    assign active      = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hsync_on    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vsync_on    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign first_pixel = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + V_ONE;
        end else begin
            h_cnt <= h_cnt + H_ONE;
        end
    end

    // Last clock of the final visible line: everything after it is blanked,
    // so flipping the displayed buffer here cannot tear a frame.
    assign swap_point = h_wrap && (v_cnt == V_SWAP);
    assign do_swap    = swap_point && (swap_pending || swap_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            front_buf    <= 1'b0;
            swap_pending <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= do_swap;
            if (do_swap) begin
                front_buf    <= ~front_buf;
                swap_pending <= 1'b0;
            end else begin
                swap_pending <= swap_pending | swap_req;
            end
        end
    end

    // Reads always hit the front half and writes the back half, so the two ports never collide.
    assign wr_ok   = wr_en && ({1'b0, wr_x} < WX_LIM) && ({1'b0, wr_y} < WY_LIM);
    assign wr_addr = {~front_buf, wr_x, wr_y};
    assign rd_addr = {front_buf, H_BITS'(h_cnt), V_BITS'(v_cnt)};

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // Timing pins are delayed one clock so they line up with the RAM read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            VGA_HSYNC   <= ~SYNC_POL;
            VGA_VSYNC   <= ~SYNC_POL;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            VGA_HSYNC   <= hsync_on ? SYNC_POL : ~SYNC_POL;
            VGA_VSYNC   <= vsync_on ? SYNC_POL : ~SYNC_POL;
            VGA_BLANK_N <= active;
            frame_start <= first_pixel;
        end
    end

    assign {VGA_R, VGA_G, VGA_B} = VGA_BLANK_N ? rd_data : 24'd0;

endmodule
